// File: rtl/dominos_rom_loader.sv
// Dominos ROM loader: splits the HPS ioctl byte stream into per-region ROM write strobes and gates the core reset.
// Latency: one cycle from Dl_Wr_I to Rom_We_O. The core is released 1+16+1 cycles after the download ends.
// Backpressure: none. A byte can be accepted on every cycle; bytes that arrive outside a download are dropped.
module dominos_rom_loader #(
   parameter logic [16:0] REG0_BASE  = 17'h00000,
   parameter logic [16:0] REG1_BASE  = 17'h00800,
   parameter logic [16:0] REG2_BASE  = 17'h01000,
   parameter logic [16:0] REG3_BASE  = 17'h01200,
   parameter logic [16:0] IMG_SIZE   = 17'h01300,
   parameter int unsigned SETTLE_CYC = 16
) (
   input  logic        Clk_I,
   input  logic        Reset_I,
   input  logic        Dl_Active_I,
   input  logic        Dl_Wr_I,
   input  logic [16:0] Dl_Addr_I,
   input  logic [7:0]  Dl_Data_I,
   output logic [3:0]  Rom_We_O,
   output logic [11:0] Rom_Addr_O,
   output logic [7:0]  Rom_Data_O,
   output logic        Core_Reset_n_O,
   output logic        Load_Done_O,
   output logic        Load_Err_O
);

   localparam int SW = $clog2(SETTLE_CYC + 1);
   localparam logic [16:0] CNT_MAX = 17'h1FFFF;

   typedef enum logic [2:0] {IDLE, LOAD, CHECK, SETTLE, RUN, ERROR} state_t;

   state_t        state_q, state_d;
   logic [16:0]   cnt_q, cnt_d;
   logic [SW-1:0] settle_q, settle_d;
   logic          ovr_q, ovr_d;
   logic          ord_q, ord_d;
   logic [3:0]    we_q, we_d;
   logic [11:0]   addr_q, addr_d;
   logic [7:0]    data_q, data_d;
   logic          core_rst_n_q, core_rst_n_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [16:0]   rel;

   // Next state, byte decode, error flags and registered output values.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      settle_d = settle_q;
      ovr_d    = ovr_q;
      ord_d    = ord_q;
      we_d     = 4'b0000;
      addr_d   = addr_q;
      data_d   = data_q;
      rel      = 17'h00000;

      case (state_q)
         IDLE: begin
            if (Dl_Active_I) state_d = LOAD;
         end
         LOAD: begin
            // A byte arriving together with the falling edge of Dl_Active_I still counts.
            if (Dl_Wr_I) begin
               if (Dl_Addr_I < IMG_SIZE) begin
                  if (Dl_Addr_I < REG1_BASE) begin
                     we_d = 4'b0001;
                     rel  = Dl_Addr_I - REG0_BASE;
                  end else if (Dl_Addr_I < REG2_BASE) begin
                     we_d = 4'b0010;
                     rel  = Dl_Addr_I - REG1_BASE;
                  end else if (Dl_Addr_I < REG3_BASE) begin
                     we_d = 4'b0100;
                     rel  = Dl_Addr_I - REG2_BASE;
                  end else begin
                     we_d = 4'b1000;
                     rel  = Dl_Addr_I - REG3_BASE;
                  end
                  addr_d = rel[11:0];
                  data_d = Dl_Data_I;
                  if (Dl_Addr_I != cnt_q) ord_d = 1'b1;
                  if (cnt_q != CNT_MAX) cnt_d = cnt_q + 17'd1;
               end else begin
                  ovr_d = 1'b1;
               end
            end
            if (!Dl_Active_I) state_d = CHECK;
         end
         CHECK: begin
            settle_d = '0;
            if (cnt_q == IMG_SIZE && !ovr_q && !ord_q) state_d = SETTLE;
            else                                       state_d = ERROR;
         end
         SETTLE: begin
            if (settle_q == SW'(SETTLE_CYC - 1)) state_d = RUN;
            else                                 settle_d = settle_q + 1'b1;
         end
         RUN: begin
            if (Dl_Active_I) state_d = LOAD;
         end
         ERROR: begin
            if (Dl_Active_I) state_d = LOAD;
         end
         default: state_d = IDLE;
      endcase

      // Every new download starts with a clean count and clean error flags.
      if (state_d == LOAD && state_q != LOAD) begin
         cnt_d = 17'h00000;
         ovr_d = 1'b0;
         ord_d = 1'b0;
      end

      // The core reset drops on the very edge that sees a restart while running.
      core_rst_n_d = (state_q == RUN) && (state_d == RUN);
      done_d       = core_rst_n_d;
      err_d        = (state_d == ERROR);
   end

   // State and output registers, all cleared asynchronously.
   always_ff @(posedge Clk_I or negedge Reset_I) begin
      if (!Reset_I) begin
         state_q      <= IDLE;
         cnt_q        <= 17'h00000;
         settle_q     <= '0;
         ovr_q        <= 1'b0;
         ord_q        <= 1'b0;
         we_q         <= 4'b0000;
         addr_q       <= 12'h000;
         data_q       <= 8'h00;
         core_rst_n_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         settle_q     <= settle_d;
         ovr_q        <= ovr_d;
         ord_q        <= ord_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
         core_rst_n_q <= core_rst_n_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign Rom_We_O       = we_q;
   assign Rom_Addr_O     = addr_q;
   assign Rom_Data_O     = data_q;
   assign Core_Reset_n_O = core_rst_n_q;
   assign Load_Done_O    = done_q;
   assign Load_Err_O     = err_q;

endmodule

// File: tb/tb_dominos_rom_loader.sv
// Directed bench for dominos_rom_loader: full, short, oversize, out-of-order and interrupted downloads.
// Inputs are driven on the falling edge, and outputs are sampled on the falling edge or #1 after the rising edge.
// Every wait on the DUT is bounded, so the run always reaches its summary line.
module tb_dominos_rom_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        dl_active;
   logic        dl_wr;
   logic [16:0] dl_addr;
   logic [7:0]  dl_data;
   logic [3:0]  rom_we;
   logic [11:0] rom_addr;
   logic [7:0]  rom_data;
   logic        core_rst_n;
   logic        load_done;
   logic        load_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dominos_rom_loader dut (
      .Clk_I          (clk),
      .Reset_I        (rst_n),
      .Dl_Active_I    (dl_active),
      .Dl_Wr_I        (dl_wr),
      .Dl_Addr_I      (dl_addr),
      .Dl_Data_I      (dl_data),
      .Rom_We_O       (rom_we),
      .Rom_Addr_O     (rom_addr),
      .Rom_Data_O     (rom_data),
      .Core_Reset_n_O (core_rst_n),
      .Load_Done_O    (load_done),
      .Load_Err_O     (load_err)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [3:0] exp_we(input int a);
      if (a < 'h800)       return 4'b0001;
      else if (a < 'h1000) return 4'b0010;
      else if (a < 'h1200) return 4'b0100;
      else                 return 4'b1000;
   endfunction

   function automatic logic [11:0] exp_rel(input int a);
      if (a < 'h800)       return 12'(a);
      else if (a < 'h1000) return 12'(a - 'h800);
      else if (a < 'h1200) return 12'(a - 'h1000);
      else                 return 12'(a - 'h1200);
   endfunction

   // n in-range bytes with data = addr[7:0]; skip >= 0 moves that address to the end of the stream;
   // ovr appends a byte at 0x1300. Dl_Active_I falls together with the final byte.
   task automatic dl(input int n, input int skip, input bit ovr, input bit bounds);
      int a;
      int bad;
      int pulses;
      int total;
      logic [3:0]  ew;
      logic [11:0] ea;
      logic [7:0]  ed;
      bad    = 0;
      pulses = 0;
      ea     = 12'h000;
      ed     = 8'h00;
      total  = n + (ovr ? 1 : 0);
      @(negedge clk);
      dl_active = 1'b1;
      @(negedge clk);
      for (int i = 0; i < total; i++) begin
         if (i == n)                           a = 'h1300;
         else if (skip >= 0 && i == n - 1)     a = skip;
         else if (skip >= 0 && i >= skip)      a = i + 1;
         else                                  a = i;
         dl_wr   = 1'b1;
         dl_addr = a[16:0];
         dl_data = a[7:0];
         if (i == total - 1) dl_active = 1'b0;
         @(negedge clk);
         if (a < 'h1300) begin
            ew = exp_we(a);
            ea = exp_rel(a);
            ed = a[7:0];
         end else begin
            ew = 4'b0000;
         end
         if (rom_we !== ew || rom_addr !== ea || rom_data !== ed) bad++;
         if (rom_we !== 4'b0000) pulses++;
         if (bounds) begin
            case (a)
               'h7FF:  check_eq("we_7ff", rom_we, 4'b0001);
               'h800:  begin check_eq("we_800", rom_we, 4'b0010); check_eq("addr_800", rom_addr, 12'h000); end
               'hFFF:  check_eq("we_fff", rom_we, 4'b0010);
               'h1000: begin check_eq("we_1000", rom_we, 4'b0100); check_eq("addr_1000", rom_addr, 12'h000); end
               'h11FF: begin check_eq("we_11ff", rom_we, 4'b0100); check_eq("addr_11ff", rom_addr, 12'h1FF); end
               'h1200: begin check_eq("we_1200", rom_we, 4'b1000); check_eq("addr_1200", rom_addr, 12'h000); end
               'h1234: begin
                  check_eq("we_1234", rom_we, 4'b1000);
                  check_eq("addr_1234", rom_addr, 12'h034);
                  check_eq("data_1234", rom_data, 8'h34);
               end
               default: ;
            endcase
         end
      end
      dl_wr   = 1'b0;
      dl_addr = 17'h00000;
      dl_data = 8'h00;
      check_eq("strobe_mismatches", bad, 0);
      check_eq("strobe_pulses", pulses, n);
   endtask

   // Counts rising edges after the one that saw Dl_Active_I low, until the core is released (bounded).
   task automatic release_wait(output int n);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1) check_eq("we_single_cycle", rom_we, 4'b0000);
         if (core_rst_n) break;
      end
   endtask

   initial begin
      int n;
      rst_n     = 1'b0;
      dl_active = 1'b0;
      dl_wr     = 1'b0;
      dl_addr   = 17'h00000;
      dl_data   = 8'h00;
      repeat (3) @(negedge clk);
      check_eq("rst_we", rom_we, 4'b0000);
      check_eq("rst_addr", rom_addr, 12'h000);
      check_eq("rst_data", rom_data, 8'h00);
      check_eq("rst_core_rst_n", core_rst_n, 1'b0);
      check_eq("rst_done", load_done, 1'b0);
      check_eq("rst_err", load_err, 1'b0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("idle_core_rst_n", core_rst_n, 1'b0);

      // Clean full image, with region-boundary and release-timing checks.
      dl('h1300, -1, 1'b0, 1'b1);
      release_wait(n);
      check_eq("release_cycles", n, 18);
      check_eq("full_done", load_done, 1'b1);
      check_eq("full_err", load_err, 1'b0);

      // A stray byte while running is ignored.
      @(negedge clk);
      dl_wr   = 1'b1;
      dl_addr = 17'h00005;
      dl_data = 8'hA5;
      @(negedge clk);
      dl_wr = 1'b0;
      check_eq("run_wr_ignored", rom_we, 4'b0000);
      check_eq("run_core_rst_n", core_rst_n, 1'b1);

      // Restart while running pulls the core into reset on the edge that sees it.
      dl_active = 1'b1;
      @(posedge clk);
      #1;
      check_eq("restart_core_rst_n", core_rst_n, 1'b0);
      check_eq("restart_done", load_done, 1'b0);

      // Short image.
      dl('h12FF, -1, 1'b0, 1'b0);
      release_wait(n);
      check_eq("short_err", load_err, 1'b1);
      check_eq("short_core_rst_n", core_rst_n, 1'b0);
      check_eq("short_done", load_done, 1'b0);

      // Full image plus one byte past the end.
      dl('h1300, -1, 1'b1, 1'b0);
      release_wait(n);
      check_eq("ovr_err", load_err, 1'b1);
      check_eq("ovr_done", load_done, 1'b0);

      // Full byte count, but 0x0011 arrives last (0x0010 followed by 0x0012).
      dl('h1300, 'h11, 1'b0, 1'b0);
      release_wait(n);
      check_eq("order_err", load_err, 1'b1);
      check_eq("order_core_rst_n", core_rst_n, 1'b0);

      // A clean reload clears the error.
      dl('h1300, -1, 1'b0, 1'b0);
      release_wait(n);
      check_eq("reload_cycles", n, 18);
      check_eq("reload_done", load_done, 1'b1);
      check_eq("reload_err", load_err, 1'b0);

      // Asynchronous reset in the middle of a download.
      @(negedge clk);
      dl_active = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 'h400; i++) begin
         dl_wr   = 1'b1;
         dl_addr = 17'(i);
         dl_data = 8'(i);
         @(negedge clk);
      end
      check_eq("pre_rst_we", rom_we, 4'b0001);
      dl_addr = 17'h00400;
      dl_data = 8'h00;
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_we", rom_we, 4'b0000);
      check_eq("arst_addr", rom_addr, 12'h000);
      check_eq("arst_data", rom_data, 8'h00);
      check_eq("arst_core_rst_n", core_rst_n, 1'b0);
      check_eq("arst_done", load_done, 1'b0);
      check_eq("arst_err", load_err, 1'b0);
      dl_wr     = 1'b0;
      dl_active = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("post_rst_err", load_err, 1'b0);
      dl('h1300, -1, 1'b0, 1'b0);
      release_wait(n);
      check_eq("post_rst_cycles", n, 18);
      check_eq("post_rst_done", load_done, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
